// File: rtl/temp_sampler.sv
// temp_sampler
//   Paced temperature acquisition front end. A free-running prescaler raises
//   a tick every div+1 cycles; each tick starts one req/ack conversion. The
//   returned code is turned into a saturated signed Q7.0 value, trimmed by
//   offset, and smoothed by a 2^AVG_LOG2-entry moving average.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : 1 runs the sampler, 0 returns it to IDLE
//   div[15:0]     : tick period is div+1 cycles
//   offset[7:0]   : signed trim added to the converted value
//   adc_req       : conversion request, high while waiting for ack
//   adc_ack       : one-cycle acknowledge, adc_data valid with it
//   adc_data      : raw unsigned sensor code
//   T_out[7:0]    : averaged temperature, signed Q7.0, stable between T_valid
//   T_valid       : one-cycle strobe when T_out updates
//   init_out      : with the first T_valid after enable rises
//   err_timeout   : one-cycle pulse when a request is abandoned
//   overrun       : one-cycle pulse when a tick is dropped while busy
module temp_sampler #(
    parameter int ADC_W    = 12,
    parameter int AVG_LOG2 = 2,
    parameter int TO_MAX   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [15:0]       div,
    input  logic signed [7:0] offset,
    output logic              adc_req,
    input  logic              adc_ack,
    input  logic [ADC_W-1:0]  adc_data,
    output logic signed [7:0] T_out,
    output logic              T_valid,
    output logic              init_out,
    output logic              err_timeout,
    output logic              overrun
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;
    localparam int PW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int TW = $clog2(TO_MAX + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_PROC = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [TW-1:0]        to_q, to_d;
    logic [7:0]           data_q, data_d;
    logic signed [7:0]    buf_q [N];
    logic signed [SW-1:0] sum_q, sum_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic                 empty_q, empty_d;
    logic                 first_q, first_d;
    logic signed [7:0]    tout_q, tout_d;
    logic                 tvalid_q, tvalid_d;
    logic                 init_q, init_d;
    logic                 err_q, err_d;
    logic                 ovr_q, ovr_d;
    logic                 buf_fill, buf_wr;

    logic                 tick;
    logic signed [9:0]    t_wide;
    logic signed [7:0]    t_sat;
    logic signed [SW-1:0] t_ext, old_ext, sum_new;

    // Gating with enable makes a disable win over a coincident tick.
    // Using >= keeps the prescaler wrapping if div is lowered mid-count.
    assign tick = enable && (state_q != S_IDLE) && (cnt_q >= div);

    // Conversion of the captured top byte: centre at 128, trim, saturate.
    always_comb begin
        t_wide = $signed({2'b00, data_q}) - 10'sd128 + $signed({{2{offset[7]}}, offset});
        if (t_wide > 10'sd127)
            t_sat = 8'sd127;
        else if (t_wide < -10'sd128)
            t_sat = -8'sd128;
        else
            t_sat = t_wide[7:0];
        t_ext   = SW'(t_sat);
        old_ext = SW'(buf_q[wptr_q]);
        // An empty buffer is seeded with N copies of t so the first output is t itself.
        if (empty_q)
            sum_new = t_ext <<< AVG_LOG2;
        else
            sum_new = sum_q + t_ext - old_ext;
    end

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        data_d   = data_q;
        sum_d    = sum_q;
        wptr_d   = wptr_q;
        empty_d  = empty_q;
        first_d  = first_q;
        tout_d   = tout_q;
        tvalid_d = 1'b0;
        init_d   = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        buf_fill = 1'b0;
        buf_wr   = 1'b0;

        if (!enable || state_q == S_IDLE)
            cnt_d = '0;
        else if (tick)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 16'd1;

        if (state_q == S_IDLE) begin
            empty_d = 1'b1;
            first_d = 1'b1;
            wptr_d  = '0;
        end

        if (tick && (state_q == S_REQ || state_q == S_PROC || state_q == S_OUT))
            ovr_d = 1'b1;

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT;
                S_WAIT: begin
                    if (tick) begin
                        state_d = S_REQ;
                        to_d    = '0;
                    end
                end
                S_REQ: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (adc_ack) begin
                        data_d  = adc_data[ADC_W-1 -: 8];
                        state_d = S_PROC;
                    end else if (to_q == TW'(TO_MAX - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                S_PROC: begin
                    // Output registers load here so T_valid lands two cycles after ack.
                    sum_d    = sum_new;
                    tout_d   = 8'(sum_new >>> AVG_LOG2);
                    tvalid_d = 1'b1;
                    init_d   = first_q;
                    first_d  = 1'b0;
                    empty_d  = 1'b0;
                    if (empty_q) begin
                        buf_fill = 1'b1;
                    end else begin
                        buf_wr = 1'b1;
                        wptr_d = (wptr_q == PW'(N - 1)) ? '0 : wptr_q + 1'b1;
                    end
                    state_d = S_OUT;
                end
                S_OUT:   state_d = S_WAIT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            to_q     <= '0;
            data_q   <= '0;
            sum_q    <= '0;
            wptr_q   <= '0;
            empty_q  <= 1'b1;
            first_q  <= 1'b1;
            tout_q   <= '0;
            tvalid_q <= 1'b0;
            init_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            data_q   <= data_d;
            sum_q    <= sum_d;
            wptr_q   <= wptr_d;
            empty_q  <= empty_d;
            first_q  <= first_d;
            tout_q   <= tout_d;
            tvalid_q <= tvalid_d;
            init_q   <= init_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    // Window storage: all entries load together on a seed, else only the oldest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                buf_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (buf_fill || (buf_wr && wptr_q == PW'(i)))
                    buf_q[i] <= t_sat;
            end
        end
    end

    assign adc_req     = (state_q == S_REQ);
    assign T_out       = tout_q;
    assign T_valid     = tvalid_q;
    assign init_out    = init_q;
    assign err_timeout = err_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_temp_sampler.sv
module tb_temp_sampler;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [15:0]       div = 16'd3;
    logic signed [7:0] offset = 8'sd3;
    logic              adc_req;
    logic              adc_ack = 1'b0;
    logic [11:0]       adc_data = 12'h000;
    logic signed [7:0] T_out;
    logic              T_valid;
    logic              init_out;
    logic              err_timeout;
    logic              overrun;

    temp_sampler #(.ADC_W(12), .AVG_LOG2(2), .TO_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div(div), .offset(offset),
        .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
        .T_out(T_out), .T_valid(T_valid), .init_out(init_out),
        .err_timeout(err_timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int init;
        int when;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int ovr_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every T_valid pops one expected output from the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (overrun === 1'b1) ovr_seen++;
            if (T_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected T_valid: T_out=%0d, expected no output (cycle %0d)", T_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("T_out", int'(T_out), e.t);
                    check("init_out", int'(init_out), e.init);
                    check("valid cycle", cyc, e.when);
                end
            end else if (init_out === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL init_out without T_valid: got 1, expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (adc_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req: got adc_req=0 for 600 cycles, expected 1");
        end
    endtask

    // Answer one request after 'delay' cycles and schedule the expected output.
    task automatic sample(input logic [11:0] data, input int exp_tv, input int exp_init, input int delay);
        bit   ok;
        exp_t e;
        wait_req(ok);
        if (ok) begin
            repeat (delay) step();
            adc_data = data;
            adc_ack  = 1'b1;
            e.t    = exp_tv;
            e.init = exp_init;
            e.when = cyc + 2;
            sb.push_back(e);
            step();
            adc_ack = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        bit ok;

        // Reset held with enable high.
        enable = 1'b1;
        div    = 16'd3;
        offset = 8'sd3;
        repeat (3) step();
        check("reset adc_req", int'(adc_req), 0);
        check("reset T_out", int'(T_out), 0);
        check("reset T_valid", int'(T_valid), 0);
        check("reset init_out", int'(init_out), 0);
        check("reset err_timeout", int'(err_timeout), 0);
        check("reset overrun", int'(overrun), 0);

        // After release: one IDLE cycle, then div+1 cycles of waiting for the tick.
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (adc_req === 1'b1) break;
            n++;
        end
        check("first req latency", n, 4);

        // First sample and averaging (0xA00 -> 35, 0xC00 -> 67).
        sample(12'hA00, 35, 1, 0);
        div = 16'd20;
        sample(12'hA00, 35, 0, 0);
        sample(12'hA00, 35, 0, 0);
        sample(12'hC00, 43, 0, 0);

        // Positive saturation on a freshly seeded buffer.
        repeat (4) step();
        enable = 1'b0;
        repeat (3) step();
        offset = 8'sd10;
        enable = 1'b1;
        sample(12'hFFF, 127, 1, 0);

        // Negative saturation, then floor of a negative mean: (-512+128+117)/4 -> -67.
        repeat (4) step();
        enable = 1'b0;
        repeat (3) step();
        offset = -8'sd10;
        enable = 1'b1;
        sample(12'h000, -128, 1, 0);
        sample(12'hFFF, -67, 0, 0);
        repeat (4) step();
        check("no overrun at slow rate", ovr_seen, 0);

        // Timeout: never acknowledge.
        base = ovr_seen;
        wait_req(ok);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (adc_req !== 1'b1) break;
            n++;
            step();
        end
        check("req cycles before timeout", n, 255);
        check("err_timeout pulse", int'(err_timeout), 1);
        check("T_out held on timeout", int'(T_out), -67);
        step();
        check("err_timeout width", int'(err_timeout), 0);
        check("overrun during long REQ", int'(ovr_seen > base), 1);
        // Next tick re-requests; window now -267-(-128)+117 = -22 -> -6.
        sample(12'hFFF, -6, 0, 0);

        // div=0 with a slow ack drops ticks. Window -22+128+22 = 128 -> 32.
        repeat (4) step();
        base = ovr_seen;
        div = 16'd0;
        sample(12'hA00, 32, 0, 3);
        repeat (2) step();
        check("overrun with div=0", int'(ovr_seen > base), 1);

        // Disable during REQ, then a late ack must be ignored.
        wait_req(ok);
        enable = 1'b0;
        step();
        check("adc_req after disable", int'(adc_req), 0);
        adc_data = 12'hC00;
        adc_ack  = 1'b1;
        step();
        adc_ack = 1'b0;
        repeat (5) step();
        check("queue drained before re-enable", sb.size(), 0);

        // Re-enable: seeded buffer gives t directly (0xC00, +3 -> 67) with init.
        div    = 16'd20;
        offset = 8'sd3;
        enable = 1'b1;
        sample(12'hC00, 67, 1, 0);
        repeat (6) step();
        check("all outputs seen", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_sampler.md
# temp_sampler

Front-end acquisition stage that sits directly upstream of the temperature-derivative estimator. It paces sensor conversions with a programmable prescaler and fetches raw codes over a req/ack handshake. Each code is converted to signed Q7.0 °C with offset trim and saturation, then smoothed by a power-of-two moving average. The result is presented as `T_out` with a one-cycle `T_valid` strobe. An `init_out` pulse marks the first valid sample after enable so the estimator can re-seed its history.

## Interface
- `ADC_W`, default 12: raw sensor code width (≥ 8).
- `AVG_LOG2`, default 2: log2 of the moving-average window (window N = 2^AVG_LOG2, 0..4).
- `TO_MAX`, default 255: number of cycles to wait for `adc_ack` before abandoning a request.

- `clk` in 1: system clock; everything is single-clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: runs sampling; 0 forces IDLE.
- `div` in 16: tick period is `div`+1 cycles.
- `offset` in 8 signed: trim added in Q7.0.
- `adc_req` out 1: conversion request, held high until ack or timeout.
- `adc_ack` in 1: one-cycle strobe; `adc_data` is valid in the same cycle.
- `adc_data` in ADC_W: raw unsigned code.
- `T_out` out 8 signed: averaged temperature, Q7.0.
- `T_valid` out 1: one-cycle pulse when `T_out` updates.
- `init_out` out 1: one-cycle pulse coincident with the first `T_valid` after enable rises.
- `err_timeout` out 1: one-cycle pulse on request timeout.
- `overrun` out 1: one-cycle pulse when a tick is skipped because the block is busy.

## Operation
- FSM states are IDLE, WAIT_TICK, REQ, PROC and OUT.
- IDLE:
  - `adc_req`=0, prescaler=0, buffer marked empty.
  - Moves to WAIT_TICK when `enable`=1.
- Prescaler:
  - Counts 0..`div` while enabled.
  - Produces a tick at `cnt`==`div`, then wraps to 0.
  - With `div`=0 it ticks every cycle.
- WAIT_TICK: a tick moves the FSM to REQ.
- A tick arriving in REQ, PROC or OUT is dropped and pulses `overrun`.
- REQ:
  - `adc_req`=1 and the timeout counter increments.
  - `adc_ack`=1 captures `adc_data` and moves to PROC.
  - After TO_MAX cycles without ack: pulse `err_timeout`, move to WAIT_TICK, leave buffer and output untouched.
- Conversion in PROC:
  - `raw8` = `adc_data[ADC_W-1:ADC_W-8]`.
  - `t` = `raw8` − 128 + `offset`, computed at 10-bit signed width.
  - `t` saturates to [−128, 127].
- Averaging in PROC:
  - If the buffer is empty, all N entries and the running sum are preloaded with `t`, so there is no start-up ramp.
  - Otherwise `sum` += `t` − `oldest`, the oldest entry is overwritten with `t`, and the write pointer increments mod N.
  - `sum` is (8+AVG_LOG2)-bit signed and exact, with no overflow.
- OUT:
  - `T_out` = `sum` >>> AVG_LOG2 (arithmetic shift, floor).
  - `T_valid`=1.
  - `init_out`=1 if this is the first output since enable rose.
  - Then move to WAIT_TICK.
- Dropping `enable` in any state: next cycle is IDLE with `adc_req`=0. A late `adc_ack` is ignored. `T_out` holds its last value.

## Timing
- Reset values: `adc_req`=0, `T_out`=0, `T_valid`=0, `init_out`=0, `err_timeout`=0, `overrun`=0, FSM in IDLE, buffer empty.
- Latency is fixed at 2 cycles: ack in cycle n, PROC in n+1, `T_valid`/`T_out` registered in n+2.
- `adc_req` rises the cycle after the tick and falls the cycle after ack.
- `adc_ack` sampled outside REQ is ignored.
- An `enable` falling edge and a tick in the same cycle: `enable` wins, no request.
- An ack and the timeout in the same cycle: the ack wins.
- `T_out` is stable between `T_valid` pulses. Consumers sample only on `T_valid`.

## Test plan
- Reset: hold `rst_n`=0 with `enable`=1 → all outputs 0 and `adc_req`=0. Release → first `adc_req` after `div`+1 cycles.
- First sample: ADC_W=12, `offset`=+3, ack with 0xA00 → `T_out`=35, with `T_valid` and `init_out` both pulsing 2 cycles after the ack.
- Averaging: N=4, after the first 0xA00 send 0xA00, 0xA00, 0xC00 → `T_out` sequence 35, 35, 35, 43; `init_out` only on the first.
- Saturation:
  - 0xFFF with `offset`=+10 → 127.
  - 0x000 with `offset`=−10 → −128.
  - Both followed by `T_valid`.
- Timeout: never ack, TO_MAX=255 → `err_timeout` pulses on cycle 255 of REQ, `adc_req` drops, `T_out` unchanged, next tick re-requests.
- Enable/overrun:
  - `div`=0 with ack delayed 3 cycles → `overrun` pulses.
  - Deassert `enable` during REQ → `adc_req`=0 next cycle, a late ack produces no `T_valid`.
  - Re-enable → new `init_out` with a preloaded buffer.
